// File: rtl/instr_mem_responder.sv
// Instruction memory responder: a two-stage fetch pipeline (address register,
// synchronous array read) feeding a 4-entry response FIFO. Credit-based
// req_ready guarantees the FIFO can never overflow. flush discards all pending
// work; the array itself is loaded through an independent write port.
module instr_mem_responder #(
    parameter int size       = 32,
    parameter int addr_width = 10,
    parameter int depth      = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [size-1:0]       req_addr,
    input  logic                  flush,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [size-1:0]       rsp_instr,
    output logic [size-1:0]       rsp_addr,
    output logic                  rsp_err,
    input  logic                  wr_en,
    input  logic [addr_width-1:0] wr_addr,
    input  logic [size-1:0]       wr_data
);

    // Instruction returned for out-of-range fetches (addi x0, x0, 0).
    localparam logic [size-1:0] lp_nop   = size'(32'h0000_0013);
    localparam logic [size-1:0] lp_depth = size'(depth);

    // Instruction array
    logic [size-1:0]       r_mem [depth];

    // S1: accepted request
    logic                  r_s1_valid;
    logic [size-1:0]       r_s1_addr;
    logic                  r_s1_err;

    // S2: array read result
    logic                  r_s2_valid;
    logic [size-1:0]       r_s2_addr;
    logic [size-1:0]       r_s2_instr;
    logic                  r_s2_err;

    // Response FIFO
    logic [size-1:0]       r_fifo_instr [4];
    logic [size-1:0]       r_fifo_addr  [4];
    logic                  r_fifo_err   [4];
    logic [1:0]            r_wr_ptr;
    logic [1:0]            r_rd_ptr;
    logic [2:0]            r_count;

    // Handshake decode
    logic [2:0]            w_credit;
    logic                  w_req_ready;
    logic                  w_accept;
    logic                  w_rsp_valid;
    logic                  w_pop;
    logic                  w_push;

    // Credit counts every word already committed to a FIFO slot: queued entries
    // plus both pipeline stages. The pre-pop count is used, so a slot freed by a
    // pop only becomes available on the following cycle.
    always_comb begin
        // NOTE: every signal gets a value on every path, so no latch is inferred.
        w_credit    = r_count + 3'(r_s1_valid) + 3'(r_s2_valid);
        w_req_ready = reset && !flush && (w_credit < 3'd4);
        w_accept    = req_valid && w_req_ready;
        w_rsp_valid = (r_count != 3'd0);
        w_pop       = w_rsp_valid && rsp_ready;
        w_push      = r_s2_valid;
    end

    // Array load port; deliberately outside reset and flush control.
    always_ff @(posedge clk) begin
        // NOTE: the array is never reset -- its contents must survive reset, and
        // a resettable array could not map onto block RAM.
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // S1: register the accepted address and its range check.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every stage samples the
        // values from before this edge, which is what makes the pipeline shift.
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_err   <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_addr <= req_addr;
                r_s1_err  <= (req_addr >= lp_depth);
            end
        end
    end

    // S2: synchronous array read, skipped for out-of-range addresses. A write
    // to the same index on this edge is not seen (read-old-data).
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s2_valid <= 1'b0;
            r_s2_addr  <= '0;
            r_s2_instr <= '0;
            r_s2_err   <= 1'b0;
        end else if (flush) begin
            r_s2_valid <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_addr <= r_s1_addr;
                r_s2_err  <= r_s1_err;
                if (r_s1_err) begin
                    r_s2_instr <= lp_nop;
                end else begin
                    r_s2_instr <= r_mem[r_s1_addr[addr_width-1:0]];
                end
            end
        end
    end

    // FIFO pointers and occupancy; reset beats flush, flush beats push/pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else if (flush) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            assert (!(w_push && (r_count == 3'd4)));
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (reset && !flush && w_push) begin
            r_fifo_instr[r_wr_ptr] <= r_s2_instr;
            r_fifo_addr[r_wr_ptr]  <= r_s2_addr;
            r_fifo_err[r_wr_ptr]   <= r_s2_err;
        end
    end

    // Head entry is shown only while valid, so an empty FIFO reads as zero.
    assign req_ready = w_req_ready;
    assign rsp_valid = w_rsp_valid;
    assign rsp_instr = w_rsp_valid ? r_fifo_instr[r_rd_ptr] : '0;
    assign rsp_addr  = w_rsp_valid ? r_fifo_addr[r_rd_ptr]  : '0;
    assign rsp_err   = w_rsp_valid ? r_fifo_err[r_rd_ptr]   : 1'b0;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: reset, in-order streaming,
// backpressure credit, out-of-range NOP, flush, same-edge write, mid-stream reset.
module tb_instr_mem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic        rsp_err;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;

    int n_cmp = 0;
    int n_mis = 0;
    int acc;

    instr_mem_responder #(.size(32), .addr_width(10), .depth(1024)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and land 1 time unit after it.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
        rsp_ready = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;

        // Reset state
        next();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_instr", rsp_instr, 32'h0);
        check("rst_rsp_addr",  rsp_addr,  32'h0);
        check("rst_rsp_err",   32'(rsp_err), 32'd0);

        // Preload mem[i] = 0xA0 + i while still in reset
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 10'(i); wr_data = 32'hA0 + 32'(i);
            next();
        end
        wr_en = 1'b0;
        check("rst_hold_ready", 32'(req_ready), 32'd0);

        reset = 1'b1;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'd1);

        // Back-to-back fetch of 0..3, consumer always ready
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_valid = (i < 4);
            req_addr  = 32'(i);
            next();
            if (i < 2) begin
                check("s1_lat_valid", 32'(rsp_valid), 32'd0);
            end else begin
                check("s1_valid", 32'(rsp_valid), 32'd1);
                check("s1_instr", rsp_instr, 32'hA0 + 32'(i - 2));
                check("s1_addr",  rsp_addr,  32'(i - 2));
            end
        end
        req_valid = 1'b0;
        next();
        check("s1_drained", 32'(rsp_valid), 32'd0);

        // Backpressure: exactly 4 accepted
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            req_addr = 32'd4 + 32'(acc);
            #1;
            check("bp_ready", 32'(req_ready), 32'(c < 4));
            if (req_ready) acc++;
            next();
        end
        check("bp_accepted", 32'(acc), 32'd4);
        check("bp_head_instr", rsp_instr, 32'hA4);
        check("bp_head_addr",  rsp_addr,  32'd4);
        check("bp_head_err",   32'(rsp_err), 32'd0);
        next();
        check("bp_hold_instr", rsp_instr, 32'hA4);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check("bp_ready_prepop", 32'(req_ready), 32'd0);
        next();
        check("bp_ready_postpop", 32'(req_ready), 32'd1);
        check("bp_instr5", rsp_instr, 32'hA5);
        next();
        check("bp_instr6", rsp_instr, 32'hA6);
        next();
        check("bp_instr7", rsp_instr, 32'hA7);
        check("bp_addr7",  rsp_addr,  32'd7);
        next();
        check("bp_drained", 32'(rsp_valid), 32'd0);

        // Out-of-range address
        req_valid = 1'b1; req_addr = 32'd1024;
        next();
        req_valid = 1'b0;
        next();
        check("oor_lat", 32'(rsp_valid), 32'd0);
        next();
        check("oor_valid", 32'(rsp_valid), 32'd1);
        check("oor_instr", rsp_instr, 32'h0000_0013);
        check("oor_err",   32'(rsp_err), 32'd1);
        check("oor_addr",  rsp_addr, 32'd1024);
        next();
        check("oor_drained", 32'(rsp_valid), 32'd0);

        // Flush with 2 in flight and 2 queued
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_addr = 32'(i);
            next();
        end
        check("fl_pre_valid", 32'(rsp_valid), 32'd1);
        check("fl_pre_instr", rsp_instr, 32'hA0);
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'd8;
        #1;
        check("fl_ready_during", 32'(req_ready), 32'd0);
        next();
        flush = 1'b0;
        #1;
        check("fl_valid_after", 32'(rsp_valid), 32'd0);
        check("fl_ready_after", 32'(req_ready), 32'd1);
        next();
        req_valid = 1'b0;
        check("fl_lat1", 32'(rsp_valid), 32'd0);
        next();
        check("fl_lat2", 32'(rsp_valid), 32'd0);
        next();
        check("fl_valid", 32'(rsp_valid), 32'd1);
        check("fl_instr", rsp_instr, 32'hA8);
        check("fl_addr",  rsp_addr,  32'd8);
        rsp_ready = 1'b1;
        next();
        check("fl_drained", 32'(rsp_valid), 32'd0);

        // Write to index 5 on the edge S2 reads index 5
        req_valid = 1'b1; req_addr = 32'd5;
        next();
        req_valid = 1'b0;
        wr_en = 1'b1; wr_addr = 10'd5; wr_data = 32'hBEEF;
        next();
        wr_en = 1'b0;
        next();
        check("wr_old_instr", rsp_instr, 32'hA5);
        next();
        req_valid = 1'b1; req_addr = 32'd5;
        next();
        req_valid = 1'b0;
        next();
        next();
        check("wr_new_instr", rsp_instr, 32'hBEEF);
        next();
        check("wr_drained", 32'(rsp_valid), 32'd0);

        // Reset mid-stream with FIFO full
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'd2;
        repeat (6) next();
        check("mr_full_valid", 32'(rsp_valid), 32'd1);
        check("mr_full_ready", 32'(req_ready), 32'd0);
        reset = 1'b0; req_valid = 1'b0;
        next();
        check("mr_rst_valid", 32'(rsp_valid), 32'd0);
        check("mr_rst_ready", 32'(req_ready), 32'd0);
        check("mr_rst_instr", rsp_instr, 32'h0);
        reset = 1'b1;
        #1;
        check("mr_rel_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_addr = 32'd3; rsp_ready = 1'b1;
        next();
        req_valid = 1'b0;
        next();
        next();
        check("mr_instr", rsp_instr, 32'hA3);
        check("mr_addr",  rsp_addr,  32'd3);
        next();
        check("mr_drained", 32'(rsp_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/instr_mem_responder.md
INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 Parameter size, default 32: instruction and address width.
REQ-002 Parameter addr_width, default 10: memory index width.
REQ-003 Parameter depth, default 1024: number of words in the array, always <= 2^addr_width.
REQ-004 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port reset  input  1  synchronous, active-low reset.
REQ-006 Port req_valid  input  1  fetch request present.
REQ-007 Port req_ready  output  1  responder can accept a request this cycle.
REQ-008 Port req_addr  input  size  word address; the PC advances by 1 per instruction.
REQ-009 Port flush  input  1  redirect (branch, JAL or JALR); discards all pending work.
REQ-010 Port rsp_valid  output  1  response at head of output queue.
REQ-011 Port rsp_ready  input  1  consumer accepts the response.
REQ-012 Port rsp_instr  output  size  fetched instruction word.
REQ-013 Port rsp_addr  output  size  req_addr echoed with the response.
REQ-014 Port rsp_err  output  1  request address was out of range.
REQ-015 Port wr_en  input  1  memory load strobe.
REQ-016 Port wr_addr  input  addr_width  memory load index.
REQ-017 Port wr_data  input  size  memory load data.

Function
REQ-018 Request accepted on an edge where req_valid=1 and req_ready=1; no other request is recorded.
REQ-019 Pipeline: S1 registers the accepted address; S2 performs a synchronous array read; the S2 result is pushed into a 4-entry FIFO.
REQ-020 Latency: request accepted at edge N gives rsp_valid=1 in the cycle after edge N+2 when the FIFO was empty.
REQ-021 Credit: req_ready = !flush AND (fifo_count + S1_valid + S2_valid) < 4; fifo_count is the value before any same-cycle pop.
REQ-022 The FIFO never overflows; a push with fifo_count=4 is impossible by construction, and an assertion flags it.
REQ-023 rsp_valid = (fifo_count != 0); rsp_instr, rsp_addr and rsp_err show the head entry and hold steady while rsp_valid=1 and rsp_ready=0.
REQ-024 Pop happens on an edge where rsp_valid=1 and rsp_ready=1; push and pop on the same edge leave fifo_count unchanged.
REQ-025 Responses leave in request order.
REQ-026 If req_addr >= depth, the response carries rsp_instr=32'h00000013 (NOP) and rsp_err=1, with no array access; otherwise rsp_err=0.
REQ-027 Only req_addr[addr_width-1:0] indexes the array; the range check in REQ-026 uses the full size-bit address.
REQ-028 On an edge where wr_en=1, the array is written at wr_addr; a read of the same index on that edge returns the old word.
REQ-029 On an edge where flush=1: S1_valid=0, S2_valid=0, fifo_count=0, and the FIFO pointers reset to 0; no pop is counted and no request is accepted.
REQ-030 The cycle after a flush, req_ready=1 (credit 0/4), and no pre-flush response ever appears.
REQ-031 wr_en is independent of flush and the handshakes; a write during flush still takes effect.

Reset
REQ-032 On an edge where reset=0: S1_valid, S2_valid, fifo_count and pointers are 0; rsp_valid=0 and rsp_instr, rsp_addr, rsp_err read 0.
REQ-033 Reset takes precedence over flush, requests and pops; the array contents are NOT reset, and wr_en still writes during reset.
REQ-034 req_ready=0 while reset=0; req_ready=1 the first cycle after reset releases.

Verification
REQ-035 Load words 0..3 = 0xA0..0xA3, issue addr 0,1,2,3 back-to-back, rsp_ready=1 -> first rsp_valid 2 cycles after first accept, instructions 0xA0..0xA3 in order, rsp_addr 0..3, one per cycle.
REQ-036 Hold rsp_ready=0, stream requests -> exactly 4 accepted, then req_ready=0; release rsp_ready -> 4 ordered responses, and req_ready returns the cycle after the first pop.
REQ-037 Request addr 1024 (depth=1024) -> rsp_instr=0x00000013, rsp_err=1, rsp_addr=1024.
REQ-038 Flush with 2 in flight and 2 queued, while req_valid=1 at addr 8 -> no old responses, addr 8 not accepted that cycle, next cycle req_ready=1, and a fresh request for addr 8 returns mem[8].
REQ-039 wr_en to index 5 = 0xBEEF on the same edge S2 reads index 5 -> that response returns the old word; a later request returns 0xBEEF.
REQ-040 Assert reset mid-stream with FIFO full -> next cycle rsp_valid=0 and req_ready=0; after release, a request to a preloaded address returns the preloaded value.
